// File: rtl/interp_window_reader.sv
// Read side of the interpolation sample buffer: a circular store of signed samples that
// serves sliding TAPS-wide windows per row and discards the TAPS-1 tail samples of each row.
module interp_window_reader #(
  parameter int DATA_WIDTH = 14,
  parameter int TAPS       = 8,
  parameter int DEPTH      = 16,
  parameter int ROW_LEN    = 72
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_full,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [TAPS*DATA_WIDTH-1:0] win_data,
  output logic                       win_last,
  output logic                       overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WIN_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int DISC_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [CNT_W-1:0]  TAPS_C       = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [WIN_W-1:0]  WIN_LAST_IDX = WIN_W'(ROW_LEN - TAPS);
  localparam logic [DISC_W-1:0] DISC_INIT    = DISC_W'(TAPS - 1);

  typedef enum logic {
    S_STREAM,
    S_DISCARD
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [WIN_W-1:0]      win_cnt_q,  win_cnt_d;
  logic [DISC_W-1:0]     disc_cnt_q, disc_cnt_d;
  logic                  overflow_q, overflow_d;
  state_e                state_q,    state_d;

  logic wr_accept;
  logic pop;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    win_cnt_d  = win_cnt_q;
    disc_cnt_d = disc_cnt_q;
    state_d    = state_q;
    pop        = 1'b0;
    win_valid  = 1'b0;
    win_last   = 1'b0;

    wr_full    = (count_q == DEPTH_C);
    // A write arriving while full is lost even if a pop frees a slot this cycle.
    wr_accept  = wr_en & ~wr_full;
    overflow_d = overflow_q | (wr_en & wr_full);

    case (state_q)
      S_STREAM: begin
        win_valid = (count_q >= TAPS_C);
        win_last  = win_valid && (win_cnt_q == WIN_LAST_IDX);
        if (win_valid && win_ready) begin
          pop = 1'b1;
          if (win_last) begin
            win_cnt_d = '0;
            if (TAPS > 1) begin
              disc_cnt_d = DISC_INIT;
              state_d    = S_DISCARD;
            end
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
      end
      S_DISCARD: begin
        // Drop the row tail one sample per cycle, stalling while the buffer is empty.
        if (count_q != '0) begin
          pop        = 1'b1;
          disc_cnt_d = disc_cnt_q - DISC_W'(1);
          if (disc_cnt_q == DISC_W'(1)) begin
            state_d = S_STREAM;
          end
        end
      end
      default: state_d = S_STREAM;
    endcase

    if (wr_accept) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(wr_accept) - CNT_W'(pop);

    // Clear wins over a same-cycle write or pop; stored samples are simply abandoned.
    if (clear) begin
      mem_d      = mem_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      win_cnt_d  = '0;
      disc_cnt_d = '0;
      overflow_d = 1'b0;
      state_d    = S_STREAM;
    end
  end

  // Window slices wrap around the ring; PTR_W-bit addition gives the modulo for free.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < TAPS; i++) begin
      win_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  assign overflow = overflow_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, because the window is read straight from it and
      // must show zeros after reset rather than stale or unknown samples.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      win_cnt_q  <= '0;
      disc_cnt_q <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_STREAM;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      win_cnt_q  <= win_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_interp_window_reader.sv
// Directed bench for interp_window_reader with ROW_LEN=10: windowing, row discard,
// backpressure, overflow, sign integrity, clear priority and asynchronous reset.
module tb_interp_window_reader;

  localparam int DW   = 14;
  localparam int TAPS = 8;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic               wr_en;
  logic [DW-1:0]      wr_data;
  logic               wr_full;
  logic               win_valid;
  logic               win_ready;
  logic [TAPS*DW-1:0] win_data;
  logic               win_last;
  logic               overflow;

  int n_checks = 0;
  int n_errors = 0;

  interp_window_reader #(
    .DATA_WIDTH(DW),
    .TAPS      (TAPS),
    .DEPTH     (16),
    .ROW_LEN   (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .win_last (win_last),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [DW-1:0] d;
    logic          rdy;
    logic          exp_valid;
    logic          exp_last;
    int            exp_start;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [DW-1:0] d, input logic rdy);
    wr_en     = we;
    wr_data   = d;
    win_ready = rdy;
  endtask

  task automatic do_clear(input logic we, input logic [DW-1:0] d);
    drive(we, d, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b0, '0, 1'b0);
  endtask

  // Window of consecutive integer samples beginning at start.
  function automatic logic [TAPS*DW-1:0] win_of(input int start);
    logic [TAPS*DW-1:0] w;
    for (int i = 0; i < TAPS; i++) w[i*DW +: DW] = DW'(start + i);
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [DW-1:0] sv [TAPS];
    logic [TAPS*DW-1:0]   sw;

    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset win_valid", win_valid, 0);
    check("reset win_last", win_last, 0);
    check("reset wr_full", wr_full, 0);
    check("reset overflow", overflow, 0);
    check("reset win_data", win_data, 0);
    rst_n = 1'b1;
    tick();

    // First window: valid only after the 8th write.
    for (int j = 1; j <= 8; j++) begin
      drive(1'b1, DW'(j), 1'b1);
      check($sformatf("first fill valid@%0d", j), win_valid, 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("first win_valid", win_valid, 1);
    check("first win_data", win_data, win_of(1));
    check("first win_last", win_last, 0);

    // Row of 10 samples: windows 0,1,2 then a 7-cycle discard, then windows 10,11,12.
    do_clear(1'b0, '0);
    for (int c = 0; c < 22; c++) vecs[c] = '{(c < 20), DW'(c), 1'b1, 1'b0, 1'b0, 0};
    vecs[8].exp_valid  = 1'b1; vecs[8].exp_start  = 0;
    vecs[9].exp_valid  = 1'b1; vecs[9].exp_start  = 1;
    vecs[10].exp_valid = 1'b1; vecs[10].exp_start = 2;  vecs[10].exp_last = 1'b1;
    vecs[18].exp_valid = 1'b1; vecs[18].exp_start = 10;
    vecs[19].exp_valid = 1'b1; vecs[19].exp_start = 11;
    vecs[20].exp_valid = 1'b1; vecs[20].exp_start = 12; vecs[20].exp_last = 1'b1;
    for (int c = 0; c < 22; c++) begin
      drive(vecs[c].we, vecs[c].d, vecs[c].rdy);
      check($sformatf("row c%0d valid", c), win_valid, vecs[c].exp_valid);
      check($sformatf("row c%0d last", c), win_last, vecs[c].exp_last);
      if (vecs[c].exp_valid)
        check($sformatf("row c%0d data", c), win_data, win_of(vecs[c].exp_start));
      tick();
    end

    // Backpressure: window holds while more samples arrive behind it.
    do_clear(1'b0, '0);
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, DW'(j), 1'b0);
      tick();
    end
    for (int j = 8; j < 13; j++) begin
      drive(1'b1, DW'(j), 1'b0);
      check($sformatf("hold%0d valid", j), win_valid, 1);
      check($sformatf("hold%0d data", j), win_data, win_of(0));
      check($sformatf("hold%0d last", j), win_last, 0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    check("bp release data", win_data, win_of(0));
    tick();
    check("bp next valid", win_valid, 1);
    check("bp next data", win_data, win_of(1));

    // Overflow: 17 writes into 16 entries, then a pop cannot rescue a write while full.
    do_clear(1'b0, '0);
    for (int j = 0; j < 17; j++) begin
      drive(1'b1, DW'(100 + j), 1'b0);
      if (j == 15) check("pre-full wr_full", wr_full, 0);
      if (j == 16) begin
        check("full wr_full", wr_full, 1);
        check("full overflow before drop", overflow, 0);
      end
      tick();
    end
    check("drop overflow", overflow, 1);
    check("drop wr_full", wr_full, 1);
    check("drop window intact", win_data, win_of(100));
    drive(1'b1, DW'(999), 1'b1);
    tick();
    check("no rescue wr_full", wr_full, 0);
    check("no rescue overflow", overflow, 1);
    check("no rescue window", win_data, win_of(101));
    drive(1'b0, '0, 1'b1);
    repeat (10) tick();
    check("sticky overflow", overflow, 1);
    do_clear(1'b0, '0);
    check("clear overflow", overflow, 0);
    check("clear wr_full", wr_full, 0);
    check("clear win_valid", win_valid, 0);

    // Sign integrity; the write presented with the clear pulse must be ignored.
    sv = '{-14'sd8192, 14'sd8191, -14'sd1, 14'sd0, 14'sd1, -14'sd2, 14'sd4096, -14'sd4097};
    for (int i = 0; i < TAPS; i++) sw[i*DW +: DW] = sv[i];
    do_clear(1'b1, DW'(77));
    for (int j = 0; j < TAPS; j++) begin
      drive(1'b1, sv[j], 1'b0);
      if (j == TAPS - 1) check("clear priority valid", win_valid, 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    check("sign valid", win_valid, 1);
    check("sign data", win_data, sw);

    // Asynchronous reset in the middle of a discard phase.
    do_clear(1'b0, '0);
    for (int j = 0; j < 17; j++) begin
      drive(1'b1, DW'(j), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    repeat (5) tick();
    check("mid-discard valid", win_valid, 0);
    check("mid-discard overflow", overflow, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async rst win_valid", win_valid, 0);
    check("async rst wr_full", wr_full, 0);
    check("async rst overflow", overflow, 0);
    check("async rst win_data", win_data, 0);
    #2 rst_n = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, DW'(200 + j), 1'b1);
      tick();
    end
    check("new row valid", win_valid, 1);
    check("new row data", win_data, win_of(200));
    check("new row last0", win_last, 0);
    drive(1'b1, DW'(208), 1'b1);
    tick();
    check("new row w1 data", win_data, win_of(201));
    check("new row w1 last", win_last, 0);
    drive(1'b1, DW'(209), 1'b1);
    tick();
    check("new row w2 data", win_data, win_of(202));
    check("new row w2 last", win_last, 1);
    drive(1'b0, '0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
